// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, NOP/HALT encodings and IF/ID control type
package pipe_pkg;
   localparam int          ADDR_W      = 16;
   localparam int          INSTR_W     = 16;
   localparam logic [15:0] NOP_INSTR   = 16'h0000;
   localparam logic [3:0]  HALT_OPCODE = 4'hF;

   typedef enum logic [1:0] {
      IFID_LOAD  = 2'd0,
      IFID_HOLD  = 2'd1,
      IFID_FLUSH = 2'd2
   } ifid_ctrl_e;
endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with load/hold/flush and async reset
module if_id_register
   import pipe_pkg::*;
#(
   parameter int ADDR_W  = pipe_pkg::ADDR_W,
   parameter int INSTR_W = pipe_pkg::INSTR_W
)(
   input  logic               clk,
   input  logic               rst,
   input  ifid_ctrl_e         ctrl,
   input  logic [INSTR_W-1:0] instr_d,
   input  logic [ADDR_W-1:0]  pc_d,
   input  logic [ADDR_W-1:0]  pc_plus1_d,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc,
   output logic [ADDR_W-1:0]  ifid_pc_plus1,
   output logic               ifid_valid
);
   // A flush only kills the instruction; the pc fields keep their last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_instr    <= INSTR_W'(NOP_INSTR);
         ifid_pc       <= '0;
         ifid_pc_plus1 <= '0;
         ifid_valid    <= 1'b0;
      end else begin
         case (ctrl)
            IFID_LOAD: begin
               ifid_instr    <= instr_d;
               ifid_pc       <= pc_d;
               ifid_pc_plus1 <= pc_plus1_d;
               ifid_valid    <= 1'b1;
            end
            IFID_FLUSH: begin
               ifid_instr <= INSTR_W'(NOP_INSTR);
               ifid_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC, next-PC priority, fetch counter; optional halt via IFETCH_HALT_EN
module instruction_fetch_unit
   import pipe_pkg::*;
#(
   parameter int                ADDR_W   = pipe_pkg::ADDR_W,
   parameter int                INSTR_W  = pipe_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc,
   output logic [ADDR_W-1:0]  ifid_pc_plus1,
   output logic               ifid_valid,
`ifdef IFETCH_HALT_EN
   output logic               halted,
`endif
   output logic [15:0]        fetch_count
);
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus1;
   logic [ADDR_W-1:0] pc_next;
   logic              count_inc;
   logic              halt_q;
   logic              halt_next;
   ifid_ctrl_e        ctrl;

   assign imem_addr = pc;
   assign pc_plus1  = pc + ADDR_W'(1);

   // Priority: redirect, then stall, then halted bubble, then normal fetch.
   always_comb begin
      ctrl      = IFID_LOAD;
      pc_next   = pc_plus1;
      count_inc = 1'b1;
      halt_next = halt_q;
      if (redirect) begin
         ctrl      = IFID_FLUSH;
         pc_next   = redirect_pc;
         count_inc = 1'b0;
         halt_next = 1'b0;
      end else if (stall) begin
         ctrl      = IFID_HOLD;
         pc_next   = pc;
         count_inc = 1'b0;
      end else if (halt_q) begin
         ctrl      = IFID_FLUSH;
         pc_next   = pc;
         count_inc = 1'b0;
      end else begin
`ifdef IFETCH_HALT_EN
         halt_next = (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         fetch_count <= '0;
      end else begin
         pc <= pc_next;
         if (count_inc && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
      end
   end

`ifdef IFETCH_HALT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) halt_q <= 1'b0;
      else     halt_q <= halt_next;
   end
   assign halted = halt_q;
`else
   assign halt_q = 1'b0;
`endif

   if_id_register #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_ifid (
      .clk           (clk),
      .rst           (rst),
      .ctrl          (ctrl),
      .instr_d       (imem_data),
      .pc_d          (pc),
      .pc_plus1_d    (pc_plus1),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .ifid_pc_plus1 (ifid_pc_plus1),
      .ifid_valid    (ifid_valid)
   );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_pc_plus1;
   logic        ifid_valid;
   logic [15:0] fetch_count;
`ifdef IFETCH_HALT_EN
   logic        halted;
`endif

   int errors = 0;
   int checks = 0;
   bit run_cmp = 1'b0;

   // reference model state
   int m_pc, m_instr, m_ipc, m_ipc1, m_valid, m_count, m_halted;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input int a);
      logic [15:0] w;
      w = 16'h1000 + 16'(a);
      return w;
   endfunction

   assign imem_data = mem_word(int'(imem_addr));

   instruction_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .ifid_pc_plus1 (ifid_pc_plus1),
      .ifid_valid    (ifid_valid),
`ifdef IFETCH_HALT_EN
      .halted        (halted),
`endif
      .fetch_count   (fetch_count)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      logic [15:0] f;
      if (rst) begin
         m_pc = 0; m_instr = 0; m_ipc = 0; m_ipc1 = 0;
         m_valid = 0; m_count = 0; m_halted = 0;
      end else if (redirect) begin
         m_pc = int'(redirect_pc); m_valid = 0; m_instr = 0; m_halted = 0;
      end else if (stall) begin
      end else if (m_halted != 0) begin
         m_valid = 0; m_instr = 0;
      end else begin
         f = mem_word(m_pc);
         m_instr = int'(f);
         m_ipc   = m_pc;
         m_ipc1  = (m_pc + 1) % 65536;
         m_valid = 1;
         m_pc    = (m_pc + 1) % 65536;
         if (m_count < 65535) m_count = m_count + 1;
`ifdef IFETCH_HALT_EN
         if (f[15:12] == 4'hF) m_halted = 1;
`endif
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         check("imem_addr", int'(imem_addr), m_pc);
         check("ifid_instr", int'(ifid_instr), m_instr);
         check("ifid_pc", int'(ifid_pc), m_ipc);
         check("ifid_pc_plus1", int'(ifid_pc_plus1), m_ipc1);
         check("ifid_valid", int'(ifid_valid), m_valid);
         check("fetch_count", int'(fetch_count), m_count);
`ifdef IFETCH_HALT_EN
         check("halted", int'(halted), m_halted);
`endif
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_addr"}, int'(imem_addr), 0);
      check({tag, "_instr"}, int'(ifid_instr), 0);
      check({tag, "_pc"}, int'(ifid_pc), 0);
      check({tag, "_pc1"}, int'(ifid_pc_plus1), 0);
      check({tag, "_valid"}, int'(ifid_valid), 0);
      check({tag, "_count"}, int'(fetch_count), 0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
      #1 check_reset_values("rst0");
      #7 rst = 1'b0;
      run_cmp = 1'b1;

      @(negedge clk); check("seq_addr0", int'(imem_addr), 0);
      @(negedge clk); check("seq_i0", int'(ifid_instr), 16'h1000);
      check("seq_a1", int'(imem_addr), 1);
      @(negedge clk); check("seq_i1", int'(ifid_instr), 16'h1001);
      check("seq_pc1", int'(ifid_pc), 1);
      @(negedge clk); check("seq_i2", int'(ifid_instr), 16'h1002);
      check("seq_pc2", int'(ifid_pc), 2);
      check("seq_v2", int'(ifid_valid), 1);
      check("seq_cnt3", int'(fetch_count), 3);

      stall = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("stall_addr", int'(imem_addr), 3);
         check("stall_instr", int'(ifid_instr), 16'h1002);
         check("stall_cnt", int'(fetch_count), 3);
      end
      stall = 1'b0;
      @(negedge clk); check("resume_instr", int'(ifid_instr), 16'h1003);
      check("resume_cnt", int'(fetch_count), 4);
      @(negedge clk); check("pre_redir_addr", int'(imem_addr), 5);

      redirect = 1'b1; redirect_pc = 16'h0040;
      @(negedge clk); redirect = 1'b0;
      check("redir_valid", int'(ifid_valid), 0);
      check("redir_instr", int'(ifid_instr), 0);
      check("redir_pc_hold", int'(ifid_pc), 4);
      check("redir_cnt", int'(fetch_count), 5);
      @(negedge clk); check("redir_tgt_instr", int'(ifid_instr), 16'h1040);
      check("redir_tgt_pc", int'(ifid_pc), 16'h0040);

      redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0010;
      @(negedge clk); redirect = 1'b0; stall = 1'b0;
      check("rs_addr", int'(imem_addr), 16'h0010);
      check("rs_valid", int'(ifid_valid), 0);

      redirect = 1'b1; redirect_pc = 16'hFFFF;
      @(negedge clk); redirect = 1'b0;
      @(negedge clk);
      check("wrap_instr", int'(ifid_instr), 16'h0FFF);
      check("wrap_pc", int'(ifid_pc), 16'hFFFF);
      check("wrap_pc1", int'(ifid_pc_plus1), 0);
      check("wrap_addr", int'(imem_addr), 0);

      repeat (7) @(negedge clk);
      check("mid_addr7", int'(imem_addr), 7);
      #2 rst = 1'b1;
      #1 check_reset_values("rst_mid");
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) == 0) redirect_pc = 16'hFFF0 + 16'($urandom_range(0, 15));
         else                           redirect_pc = 16'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
      @(negedge clk); stall = 1'b0; redirect = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage (IF) of the 16-bit 5-stage pipeline; the requesting end of the instruction-memory read interface.
- Owns the PC and drives the word address to InstructionMemory each cycle.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall from hazard detection and redirect/flush from branch resolution.

Parameters:
- ADDR_W, 16: PC / memory word-address width.
- INSTR_W, 16: instruction width.
- RESET_PC, 16'h0000: PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  ADDR_W  word address to instruction memory; always equal to current pc.
- imem_data  input  INSTR_W  instruction from memory; combinational read of imem_addr, valid same cycle.
- stall  input  1  hazard unit: hold PC and IF/ID.
- redirect  input  1  branch/jump taken: load target, flush IF/ID.
- redirect_pc  input  ADDR_W  redirect target word address.
- ifid_instr  output  INSTR_W  registered instruction to decode.
- ifid_pc  output  ADDR_W  address the instruction was fetched from.
- ifid_pc_plus1  output  ADDR_W  ifid_pc+1, modulo 2^ADDR_W, for link/branch offset.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  output  16  number of instructions accepted into IF/ID; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc=RESET_PC; ifid_instr=NOP_INSTR (16'h0000); ifid_pc=0; ifid_pc_plus1=0; ifid_valid=0; fetch_count=0.
  - First rising edge after rst deasserts captures mem[RESET_PC].
- imem_addr = pc combinationally; no other address source.
- Per-edge priority: redirect > stall > normal.
- Redirect (regardless of stall):
  - pc<=redirect_pc; ifid_valid<=0; ifid_instr<=NOP_INSTR.
  - ifid_pc and ifid_pc_plus1 hold their values.
  - Instruction on imem_data that cycle is discarded; fetch_count unchanged.
  - Next edge captures mem[redirect_pc]: one-bubble penalty.
- Stall (no redirect): pc, all ifid_* and fetch_count hold; imem_addr stays stable.
- Normal edge:
  - ifid_instr<=imem_data; ifid_pc<=pc; ifid_pc_plus1<=pc+1; ifid_valid<=1; pc<=pc+1; fetch_count<=fetch_count+1 (saturating).
- Wrap: pc=2^ADDR_W-1 increments to 0; ifid_pc_plus1 wraps identically.
- Throughput: one instruction per cycle absent stall/redirect. Latency: address issued cycle N appears on ifid_* after edge N.
- Back-to-back redirects: each takes effect; only the last target is fetched.

Optional Feature:
- Macro IFETCH_HALT_EN.
- When defined:
  - A normal-edge capture with imem_data[15:12]==HALT_OPCODE (4'hF) latches the instruction with ifid_valid=1 and sets internal halted.
  - While halted: pc frozen; each subsequent non-stall edge loads bubble (ifid_valid=0, NOP_INSTR); fetch_count frozen.
  - redirect clears halted (halt was wrong-path) and proceeds as a normal redirect; rst clears halted.
  - Extra output port halted (1 bit), reset 0.
- When undefined: 4'hF is fetched like any other instruction; no halted port.

Decomposition:
- Package pipe_pkg: ADDR_W, INSTR_W, NOP_INSTR, HALT_OPCODE constants; shared with decode and InstructionMemory.
- One sub-module, if_id_register: IF/ID flops with load/hold/flush controls and async reset.
- instruction_fetch_unit contains the PC, next-PC mux, priority logic, counter and optional halt logic.

Test Plan:
- Memory model mem[i]=16'h1000+i; rst high 8 ns then low, no stall/redirect -> imem_addr 0,1,2,3 on successive cycles; ifid_instr 1000,1001,1002 with ifid_pc 0,1,2 and ifid_valid=1; fetch_count=3 after the third edge.
- stall high 2 cycles while pc=3 -> imem_addr holds 3; ifid_instr holds 16'h1002; fetch_count holds; resumes with 16'h1003.
- redirect with redirect_pc=16'h0040 while pc=5 -> next edge ifid_valid=0, ifid_instr=0000; following edge ifid_instr=16'h1040, ifid_pc=16'h0040.
- redirect and stall asserted together with redirect_pc=16'h0010 -> redirect wins; pc=16'h0010, bubble inserted.
- redirect_pc=16'hFFFF -> captures mem[FFFF] with ifid_pc_plus1=0000; next fetch address 0000.
- rst pulsed mid-stream at pc=7 -> all outputs return to reset values immediately without a clock edge. With IFETCH_HALT_EN and mem[2]=16'hF000 -> halted=1 after capturing F000; pc frozen at 3; bubbles follow until redirect.
